// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared FPU constants and int-to-float FSM state encoding
package fpu_pkg;

    localparam int FP_BIAS     = 127;
    localparam int FP_EXP_W    = 8;
    localparam int FP_FRAC_W   = 23;
    // Biased exponent of a value whose leading one sits in bit 31 (127 + 31)
    localparam int FP_I2F_EXP0 = 158;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_NORM = 2'd1,
        S_DONE = 2'd2
    } i2f_state_e;

endpackage

// File: rtl/fpu_i2f_round.sv
// rtl/fpu_i2f_round.sv - packs a normalised magnitude into a single-precision word; rounding under FPU_I2F_ROUND_EN
module fpu_i2f_round
    import fpu_pkg::*;
(
    input  logic [31:0]         mag_i,
    input  logic [FP_EXP_W-1:0] exp_i,
    input  logic                sign_i,
    output logic [31:0]         result_o
);

    logic [FP_FRAC_W-1:0] frac;
    logic                 inc;
    logic [FP_FRAC_W:0]   frac_sum;

    // Bit 31 is the hidden leading one and never reaches the result
    assign frac = mag_i[30:8];

`ifdef FPU_I2F_ROUND_EN
    logic guard;
    logic sticky;
    logic unused_hidden;

    assign guard         = mag_i[7];
    assign sticky        = |mag_i[6:0];
    assign unused_hidden = mag_i[31];
    // Round to nearest, ties to even
    assign inc           = guard & (sticky | frac[0]);
`else
    logic unused_bits;

    // Truncation toward zero: everything below the fraction is dropped
    assign unused_bits = mag_i[31] ^ (^mag_i[7:0]);
    assign inc         = 1'b0;
`endif

    assign frac_sum = {1'b0, frac} + {{FP_FRAC_W{1'b0}}, inc};

    // A carry out of the fraction leaves frac_sum[22:0] at zero and bumps the exponent
    assign result_o = {sign_i,
                       exp_i + {{(FP_EXP_W-1){1'b0}}, frac_sum[FP_FRAC_W]},
                       frac_sum[FP_FRAC_W-1:0]};

endmodule

// File: rtl/fpu_int_to_float.sv
// rtl/fpu_int_to_float.sv - iterative 32-bit integer to IEEE-754 single converter; FPU_I2F_ROUND_EN selects round-to-nearest-even
module fpu_int_to_float
    import fpu_pkg::*;
#(
    parameter bit SIGNED_IN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] A,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        busy
);

    i2f_state_e          state_q;
    logic [31:0]         mag_q;
    logic [FP_EXP_W-1:0] exp_q;
    logic                sign_q;
    logic                out_valid_q;
    logic [31:0]         result_q;

    logic                a_sign;
    logic [31:0]         a_mag;
    logic [31:0]         rounded;

    // Operand sign and magnitude; -0x80000000 wraps back to 0x80000000, which is the right unsigned magnitude
    assign a_sign = SIGNED_IN & A[31];
    assign a_mag  = a_sign ? (~A + 32'd1) : A;

    assign in_ready  = (state_q == S_IDLE) & ~rst;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign busy      = (state_q != S_IDLE);

    fpu_i2f_round u_round (
        .mag_i    (mag_q),
        .exp_i    (exp_q),
        .sign_i   (sign_q),
        .result_o (rounded)
    );

    // Conversion FSM: capture, shift-normalise one bit per clock, then hold the result until accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            mag_q       <= 32'd0;
            exp_q       <= '0;
            sign_q      <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= 32'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        sign_q <= a_sign;
                        mag_q  <= a_mag;
                        exp_q  <= FP_EXP_W'(FP_I2F_EXP0);
                        if (A == 32'd0) begin
                            result_q    <= 32'd0;
                            out_valid_q <= 1'b1;
                            state_q     <= S_DONE;
                        end else begin
                            state_q <= S_NORM;
                        end
                    end
                end
                S_NORM: begin
                    if (!mag_q[31]) begin
                        mag_q <= {mag_q[30:0], 1'b0};
                        exp_q <= exp_q - 1'b1;
                    end else begin
                        result_q    <= rounded;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_int_to_float.sv
// tb/tb_fpu_int_to_float.sv - self-checking bench for fpu_int_to_float with a real-arithmetic reference model
module tb_fpu_int_to_float;

    localparam bit SIGNED_IN = 1'b1;

`ifdef FPU_I2F_ROUND_EN
    localparam logic [31:0] E_01000003 = 32'h4B800002;
    localparam logic [31:0] E_7FFFFFFF = 32'h4F000000;
`else
    localparam logic [31:0] E_01000003 = 32'h4B800001;
    localparam logic [31:0] E_7FFFFFFF = 32'h4EFFFFFF;
`endif
    localparam logic [31:0] E_80000000 = SIGNED_IN ? 32'hCF000000 : 32'h4F000000;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    fpu_int_to_float #(.SIGNED_IN(SIGNED_IN)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic bit is_neg(input logic [31:0] a);
        return SIGNED_IN && a[31];
    endfunction

    function automatic longint mag_of(input logic [31:0] a);
        longint v;
        v = longint'({32'd0, a});
        if (is_neg(a)) v = 64'd4294967296 - v;
        return v;
    endfunction

    function automatic int lz_of(input longint m);
        int top;
        top = -1;
        for (int i = 0; i < 32; i++)
            if (m[i]) top = i;
        return 31 - top;
    endfunction

    // Exact value through a double, then narrowed to single with the build's rounding rule
    function automatic logic [31:0] model(input logic [31:0] a);
        longint      m;
        logic [63:0] db;
        int          e;
        logic [30:0] body;
        logic [28:0] rem;
        m = mag_of(a);
        if (m == 0) return 32'd0;
        db   = $realtobits(real'(m));
        e    = int'(db[62:52]) - 1023 + 127;
        body = {e[7:0], db[51:29]};
        rem  = db[28:0];
`ifdef FPU_I2F_ROUND_EN
        if (rem > 29'h1000_0000 || (rem == 29'h1000_0000 && body[0])) body = body + 31'd1;
`else
        if (rem != 29'd0) body = body;
`endif
        return {is_neg(a), body};
    endfunction

    task automatic do_op(input logic [31:0] a, input int hold, input bit use_lit, input logic [31:0] lit);
        logic [31:0] req;
        int          req_lat;
        int          k;
        longint      m;
        req = model(a);
        m   = mag_of(a);
        req_lat = (m == 0) ? 1 : 2 + lz_of(m);
        if (use_lit) chk("model_pin", req, lit);
        @(negedge clk);
        chk("in_ready_idle", in_ready, 1);
        A        = a;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        A        = $urandom;
        k = 0;
        do begin
            @(negedge clk);
            k++;
            if (!out_valid) begin
                chk("busy_norm", busy, 1);
                chk("in_ready_norm", in_ready, 0);
                in_valid = 1'($urandom_range(0, 1));
                A        = $urandom;
            end
        end while (!out_valid && k < 64);
        chk("latency", k, req_lat);
        chk("result", result, req);
        if (use_lit) chk("result_lit", result, lit);
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'($urandom_range(0, 1));
            A        = $urandom;
            @(negedge clk);
            chk("hold_valid", out_valid, 1);
            chk("hold_result", result, req);
            chk("hold_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("post_valid", out_valid, 0);
        chk("post_busy", busy, 0);
        chk("post_in_ready", in_ready, 1);
    endtask

    initial begin
        logic [31:0] a;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        A         = 32'd0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 32'd0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", in_ready, 1);

        do_op(32'd1,          0,  1'b1, 32'h3F800000);
        do_op(32'hFFFFFFFF,   1,  1'b1, SIGNED_IN ? 32'hBF800000 : 32'h4F800000);
        do_op(32'h01000003,   0,  1'b1, E_01000003);
        do_op(32'h01000001,   2,  1'b1, 32'h4B800000);
        do_op(32'h7FFFFFFF,   0,  1'b1, E_7FFFFFFF);
        do_op(32'd0,          1,  1'b1, 32'h00000000);
        do_op(32'h80000000,   10, 1'b1, E_80000000);

        // Reset in the middle of a long normalisation
        @(negedge clk);
        A        = 32'd1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_result", result, 32'd0);
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_release_in_ready", in_ready, 1);
        do_op(32'd5, 0, 1'b1, 32'h40A00000);

        for (int n = 0; n < 40; n++) begin
            a = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) a = -a;
            if ($urandom_range(0, 9) == 0) a = 32'd0;
            do_op(a, $urandom_range(0, 3), 1'b0, 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

endmodule
